// File: rtl/oitf_ctrl.sv
// Outstanding-instruction tracking FIFO for the ID/EX stage.
// Holds in-flight long-latency destinations in order and flags decode-stage RAW hazards against them.
module oitf_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int RA_W  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dis_ena,
  output logic            dis_ready,
  input  logic [RA_W-1:0] dis_rd,
  input  logic            dis_wreg,
  input  logic            dis_whi,
  input  logic            dis_wlo,
  input  logic            dis_wllbit,
  input  logic            dis_wcp0,
  input  logic [RA_W-1:0] dis_cp0_addr,
  input  logic            ret_ena,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic            rs1_en,
  input  logic [RA_W-1:0] rs2_addr,
  input  logic            rs2_en,
  input  logic            rd_hi,
  input  logic            rd_lo,
  input  logic            rd_llbit,
  input  logic            rd_cp0_en,
  input  logic [RA_W-1:0] rd_cp0_addr,
  output logic            oitf_match,
  output logic            oitf_hi_match,
  output logic            oitf_lo_match,
  output logic            oitf_LLbit_match,
  output logic            oitf_cp0_match,
  output logic            oitf_empty,
  output logic            oitf_full
);

  logic [PTR_W:0]   wptr, rptr;
  logic [PTR_W-1:0] widx, ridx;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] wreg_q, whi_q, wlo_q, wllbit_q, wcp0_q;
  logic [RA_W-1:0]  rd_q  [DEPTH];
  logic [RA_W-1:0]  cp0_q [DEPTH];
  logic             dis_fire, ret_fire;

  assign widx = wptr[PTR_W-1:0];
  assign ridx = rptr[PTR_W-1:0];

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign oitf_empty = (wptr == rptr);
  assign oitf_full  = (wptr[PTR_W] != rptr[PTR_W]) && (widx == ridx);
  assign dis_ready  = ~oitf_full;

  assign dis_fire = dis_ena & dis_ready & ~flush;
  assign ret_fire = ret_ena & ~oitf_empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
    end else begin
      if (ret_fire) begin
        valid[ridx] <= 1'b0;
        rptr        <= rptr + (PTR_W+1)'(1);
      end
      if (dis_fire) begin
        valid[widx] <= 1'b1;
        wptr        <= wptr + (PTR_W+1)'(1);
      end
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (dis_fire) begin
      rd_q[widx]     <= dis_rd;
      wreg_q[widx]   <= dis_wreg;
      whi_q[widx]    <= dis_whi;
      wlo_q[widx]    <= dis_wlo;
      wllbit_q[widx] <= dis_wllbit;
      wcp0_q[widx]   <= dis_wcp0;
      cp0_q[widx]    <= dis_cp0_addr;
    end
  end

  always_comb begin
    oitf_match       = 1'b0;
    oitf_hi_match    = 1'b0;
    oitf_lo_match    = 1'b0;
    oitf_LLbit_match = 1'b0;
    oitf_cp0_match   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        if (wreg_q[i] && (rd_q[i] != '0) &&
            ((rs1_en && (rd_q[i] == rs1_addr)) || (rs2_en && (rd_q[i] == rs2_addr))))
          oitf_match = 1'b1;
        if (rd_hi && whi_q[i])
          oitf_hi_match = 1'b1;
        if (rd_lo && wlo_q[i])
          oitf_lo_match = 1'b1;
        if (rd_llbit && wllbit_q[i])
          oitf_LLbit_match = 1'b1;
        if (rd_cp0_en && wcp0_q[i] && (cp0_q[i] == rd_cp0_addr))
          oitf_cp0_match = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oitf_ctrl.sv
// Bench for oitf_ctrl: directed scenarios plus random traffic against a queue-based reference model.
module tb_oitf_ctrl;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int RA_W  = 5;

  logic clk = 1'b0;
  logic rst, flush, dis_ena, dis_ready, ret_ena;
  logic [RA_W-1:0] dis_rd, dis_cp0_addr, rs1_addr, rs2_addr, rd_cp0_addr;
  logic dis_wreg, dis_whi, dis_wlo, dis_wllbit, dis_wcp0;
  logic rs1_en, rs2_en, rd_hi, rd_lo, rd_llbit, rd_cp0_en;
  logic oitf_match, oitf_hi_match, oitf_lo_match, oitf_LLbit_match, oitf_cp0_match;
  logic oitf_empty, oitf_full;

  typedef struct {
    logic [RA_W-1:0] rd;
    logic wreg, whi, wlo, wllbit, wcp0;
    logic [RA_W-1:0] cp0_addr;
  } ent_t;

  ent_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  oitf_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_rd(dis_rd),
    .dis_wreg(dis_wreg), .dis_whi(dis_whi), .dis_wlo(dis_wlo),
    .dis_wllbit(dis_wllbit), .dis_wcp0(dis_wcp0), .dis_cp0_addr(dis_cp0_addr),
    .ret_ena(ret_ena),
    .rs1_addr(rs1_addr), .rs1_en(rs1_en), .rs2_addr(rs2_addr), .rs2_en(rs2_en),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .rd_llbit(rd_llbit),
    .rd_cp0_en(rd_cp0_en), .rd_cp0_addr(rd_cp0_addr),
    .oitf_match(oitf_match), .oitf_hi_match(oitf_hi_match), .oitf_lo_match(oitf_lo_match),
    .oitf_LLbit_match(oitf_LLbit_match), .oitf_cp0_match(oitf_cp0_match),
    .oitf_empty(oitf_empty), .oitf_full(oitf_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs straight from the matching rules over the model queue.
  task automatic check_all();
    logic m, mh, ml, mll, mc;
    m = 0; mh = 0; ml = 0; mll = 0; mc = 0;
    foreach (q[i]) begin
      if (q[i].wreg && q[i].rd != 0 &&
          ((rs1_en && q[i].rd == rs1_addr) || (rs2_en && q[i].rd == rs2_addr))) m = 1;
      if (rd_hi && q[i].whi) mh = 1;
      if (rd_lo && q[i].wlo) ml = 1;
      if (rd_llbit && q[i].wllbit) mll = 1;
      if (rd_cp0_en && q[i].wcp0 && q[i].cp0_addr == rd_cp0_addr) mc = 1;
    end
    check("match", oitf_match, m);
    check("hi_match", oitf_hi_match, mh);
    check("lo_match", oitf_lo_match, ml);
    check("llbit_match", oitf_LLbit_match, mll);
    check("cp0_match", oitf_cp0_match, mc);
    check("empty", oitf_empty, q.size() == 0);
    check("full", oitf_full, q.size() == DEPTH);
    check("dis_ready", dis_ready, q.size() != DEPTH);
  endtask

  // Inputs are set at a negedge; check, clock, update model, return at next negedge.
  task automatic cycle();
    bit do_dis, do_ret;
    ent_t e;
    #1 check_all();
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      do_dis = dis_ena && (q.size() < DEPTH);
      do_ret = ret_ena && (q.size() > 0);
      if (do_ret) void'(q.pop_front());
      if (do_dis) begin
        e.rd = dis_rd; e.wreg = dis_wreg; e.whi = dis_whi; e.wlo = dis_wlo;
        e.wllbit = dis_wllbit; e.wcp0 = dis_wcp0; e.cp0_addr = dis_cp0_addr;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; dis_ena = 0; ret_ena = 0; dis_rd = 0; dis_wreg = 0; dis_whi = 0;
    dis_wlo = 0; dis_wllbit = 0; dis_wcp0 = 0; dis_cp0_addr = 0;
    rs1_addr = 0; rs1_en = 0; rs2_addr = 0; rs2_en = 0;
    rd_hi = 0; rd_lo = 0; rd_llbit = 0; rd_cp0_en = 0; rd_cp0_addr = 0;
  endtask

  task automatic dispatch_gpr(input logic [RA_W-1:0] rd);
    idle(); dis_ena = 1; dis_rd = rd; dis_wreg = 1;
    cycle();
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    check("rst_empty", oitf_empty, 1);
    check("rst_ready", dis_ready, 1);
    cycle();
    rst = 0;

    // Basic GPR RAW, then retire clears it.
    dispatch_gpr(8);
    idle(); rs1_addr = 8; rs1_en = 1;
    #1 check("raw_rd8", oitf_match, 1);
    ret_ena = 1;
    cycle();
    rs1_addr = 8; rs1_en = 1;
    #1 check("retired_rd8", oitf_match, 0);
    check("retired_empty", oitf_empty, 1);
    cycle();

    // r0 never matches; mult writes HI/LO.
    dispatch_gpr(0);
    idle(); dis_ena = 1; dis_whi = 1; dis_wlo = 1; rs1_addr = 0; rs1_en = 1;
    #1 check("r0_nomatch", oitf_match, 0);
    cycle();
    idle(); rd_lo = 1;
    #1 check("lo_match_mult", oitf_lo_match, 1);
    check("hi_unread", oitf_hi_match, 0);
    cycle();
    idle(); flush = 1; cycle();

    // Fill, overflow dispatch dropped, then retire oldest.
    for (int i = 1; i <= 4; i++) dispatch_gpr(i[RA_W-1:0]);
    idle();
    #1 check("full_flag", oitf_full, 1);
    check("full_ready", dis_ready, 0);
    dis_ena = 1; dis_rd = 9; dis_wreg = 1;
    cycle();
    idle(); rs2_addr = 9; rs2_en = 1;
    #1 check("dropped_rd9", oitf_match, 0);
    ret_ena = 1;
    cycle();
    for (int i = 1; i <= 4; i++) begin
      idle(); rs1_addr = i[RA_W-1:0]; rs1_en = 1;
      #1 check("after_pop", oitf_match, i != 1);
      cycle();
    end
    idle(); flush = 1; cycle();

    // Steady dispatch+retire at count=2 across pointer wrap.
    dispatch_gpr(20);
    dispatch_gpr(21);
    for (int i = 0; i < 10; i++) begin
      idle(); dis_ena = 1; ret_ena = 1; dis_rd = RA_W'(22 + i); dis_wreg = 1;
      rs1_addr = RA_W'(21 + i); rs1_en = 1; rs2_addr = RA_W'(19 + i); rs2_en = 1;
      #1 check("wrap_newest", oitf_match, 1);
      rs1_en = 0;
      #1 check("wrap_stale", oitf_match, 0);
      rs1_en = 1;
      cycle();
      check("wrap_count", q.size(), 2);
    end
    idle(); flush = 1; cycle();

    // CP0 and LLbit.
    idle(); dis_ena = 1; dis_wcp0 = 1; dis_cp0_addr = 12; cycle();
    idle(); dis_ena = 1; dis_wllbit = 1; rd_cp0_en = 1; rd_cp0_addr = 12;
    #1 check("cp0_12", oitf_cp0_match, 1);
    rd_cp0_addr = 13;
    #1 check("cp0_13", oitf_cp0_match, 0);
    cycle();
    idle(); rd_llbit = 1;
    #1 check("llbit", oitf_LLbit_match, 1);
    cycle();

    // Flush with dispatch at 3 entries.
    dispatch_gpr(5);
    idle(); flush = 1; dis_ena = 1; dis_rd = 6; dis_wreg = 1; cycle();
    idle(); rs1_addr = 6; rs1_en = 1; rs2_addr = 5; rs2_en = 1; rd_llbit = 1;
    #1 check("flush_empty", oitf_empty, 1);
    check("flush_nomatch", oitf_match, 0);
    cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      flush        = ($urandom_range(0, 63) == 0);
      dis_ena      = ($urandom_range(0, 1) == 1);
      ret_ena      = ($urandom_range(0, 9) < 4);
      dis_rd       = RA_W'($urandom_range(0, 7));
      dis_wreg     = ($urandom_range(0, 3) != 0);
      dis_whi      = ($urandom_range(0, 3) == 0);
      dis_wlo      = ($urandom_range(0, 3) == 0);
      dis_wllbit   = ($urandom_range(0, 5) == 0);
      dis_wcp0     = ($urandom_range(0, 5) == 0);
      dis_cp0_addr = RA_W'($urandom_range(10, 13));
      rs1_addr     = RA_W'($urandom_range(0, 7));
      rs1_en       = ($urandom_range(0, 1) == 1);
      rs2_addr     = RA_W'($urandom_range(0, 7));
      rs2_en       = ($urandom_range(0, 1) == 1);
      rd_hi        = ($urandom_range(0, 1) == 1);
      rd_lo        = ($urandom_range(0, 1) == 1);
      rd_llbit     = ($urandom_range(0, 1) == 1);
      rd_cp0_en    = ($urandom_range(0, 1) == 1);
      rd_cp0_addr  = RA_W'($urandom_range(10, 13));
      cycle();
    end

    // Async reset mid-cycle with entries valid.
    idle(); flush = 1; cycle();
    dispatch_gpr(3);
    dispatch_gpr(4);
    idle(); rs1_addr = 3; rs1_en = 1;
    #1 check("pre_rst_match", oitf_match, 1);
    rst = 1;
    #1 check("async_rst_empty", oitf_empty, 1);
    check("async_rst_match", oitf_match, 0);
    q.delete();
    cycle();
    rst = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
